uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 Parameter DBIT, default 8: data bits per frame; legal range 5..8.
- REQ-002 Parameter SB_TICK, default 16: oversample ticks in the stop bit; 16 means 1 stop bit, 24 means 1.5, 32 means 2.
- REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
- REQ-004 Port reset, input, 1: synchronous, active-high reset.
- REQ-005 Port s_tick, input, 1: one-clk-wide enable pulse at 16x baud, driven by the baud tick generator.
- REQ-006 Port rx, input, 1: asynchronous serial line; idle level is 1.
- REQ-007 Port dout, output, 8: received byte, LSB first; for DBIT<8 the upper bits are 0.
- REQ-008 Port rx_done_tick, output, 1: one-clk pulse when a valid frame completes.
- REQ-009 Port frame_err, output, 1: one-clk pulse when a frame has a stop bit sampled at 0.

Function
- REQ-010 rx shall pass through a 2-flop synchronizer, reset value 1; all decisions shall use the synchronized rx_s.
- REQ-011 The FSM shall have five states: IDLE, START, DATA, STOP, WAIT_HI.
- REQ-012 The FSM shall hold a 4-bit tick counter s_cnt, a 3-bit bit counter n_cnt, and an 8-bit shift register b_reg.
- REQ-013 IDLE: when rx_s==0 (evaluated every clk, regardless of s_tick), go to START and set s_cnt=0.
- REQ-014 START: on each s_tick, increment s_cnt; on the s_tick where s_cnt==7 (mid start bit):
  - rx_s==0: go to DATA, set s_cnt=0, n_cnt=0.
  - rx_s==1: treat as a glitch and return to IDLE with no output pulse.
- REQ-015 DATA: on each s_tick, increment s_cnt; on the s_tick where s_cnt==15:
  - shift rx_s into b_reg MSB (shift right) and set s_cnt=0;
  - if n_cnt==DBIT-1 go to STOP, else increment n_cnt.
- REQ-016 STOP: on each s_tick, increment s_cnt; on the s_tick where s_cnt==SB_TICK-1, sample rx_s:
  - 1: load dout from b_reg (right-aligned to DBIT), pulse rx_done_tick, go to IDLE.
  - 0: pulse frame_err, leave dout unchanged, go to WAIT_HI.
- REQ-017 WAIT_HI: stay until rx_s==1, then go to IDLE; a held-low line (break) shall produce exactly one frame_err.
- REQ-018 s_cnt shall be wide enough for SB_TICK-1 (5 bits when SB_TICK>16); s_cnt and n_cnt never wrap inside a state.
- REQ-019 While s_tick==0, only IDLE and WAIT_HI transitions shall occur; counters shall hold.
- REQ-020 rx_done_tick and frame_err shall be registered, asserted for exactly one clk in the cycle after the qualifying s_tick, and never asserted together.
- REQ-021 dout shall hold its value until the next valid frame completes.
- REQ-022 Latency from the rx edge to FSM reaction shall be 2 clk (synchronizer) plus up to 1 s_tick period.

Reset
- REQ-023 reset shall have priority over every other input, including an in-progress frame.
- REQ-024 Reset values: state=IDLE, s_cnt=0, n_cnt=0, b_reg=0, dout=0, rx_done_tick=0, frame_err=0, synchronizer flops=1.
- REQ-025 A partial frame interrupted by reset shall be discarded with no pulse on any output.

Structure
- REQ-026 State encodings and the oversample constant 16 shall live in shared package uart_pkg, which the transmitter also uses.
- REQ-027 The 2-flop synchronizer shall be a separate sub-module, sync_2ff, reusable for other async inputs.
- REQ-028 The s_tick source (baud tick generator) shall be instantiated by the parent, not inside uart_rx.

Verification
Common setup: s_tick every 4 clk; one bit is 64 clk.
- REQ-029 Frame 0x55 with a valid stop bit -> dout=0x55, one rx_done_tick, frame_err=0.
- REQ-030 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done_tick pulses, dout=0x00 then 0xFF.
- REQ-031 rx low for 5 ticks (20 clk) then high -> return to IDLE, no pulses, dout unchanged.
- REQ-032 Frame 0xA5 with stop bit 0, then line held low for 10 bit times -> one frame_err, no rx_done_tick, dout unchanged; after rx returns high, frame 0x3C is received correctly.
- REQ-033 reset asserted for 1 clk during data bit 4 of 0x81 -> all outputs 0, state IDLE; the next frame 0x7E is received correctly.
- REQ-034 DBIT=7, SB_TICK=32, frame 0x5A (7 bits) -> dout=0x5A, rx_done_tick asserted 32 ticks after stop-bit start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the 16x oversample
// constant used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_e;

  // Tick counter must reach SB_TICK-1 in the stop state and OVERSAMPLE-1 in data.
  function automatic int unsigned scnt_width(input int unsigned sb_tick);
    return (sb_tick > OVERSAMPLE) ? $clog2(sb_tick) : $clog2(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a
// selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled: mid-bit sampling, LSB first, registered
// done / framing-error pulses and a break-tolerant wait-for-idle state.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  localparam int unsigned     SCW       = scnt_width(SB_TICK);
  localparam logic [SCW-1:0]  MID_START = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0]  BIT_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0]  STOP_LAST = SCW'(SB_TICK - 1);
  localparam logic [2:0]      N_LAST    = 3'(DBIT - 1);

  rx_state_e      state_q, state_d;
  logic [SCW-1:0] s_cnt_q, s_cnt_d;
  logic [2:0]     n_cnt_q, n_cnt_d;
  logic [7:0]     b_q, b_d;
  logic [7:0]     dout_q, dout_d;
  logic           done_q, done_d;
  logic           ferr_q, ferr_d;
  logic           rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          s_cnt_d = '0;
        end
      end
      RX_START: begin
        if (s_tick) begin
          if (s_cnt_q == MID_START) begin
            if (!rx_s) begin
              state_d = RX_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SCW'(1);
          end
        end
      end
      RX_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            b_d     = {rx_s, b_q[7:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) state_d = RX_STOP;
            else                   n_cnt_d = n_cnt_q + 3'd1;
          end else begin
            s_cnt_d = s_cnt_q + SCW'(1);
          end
        end
      end
      RX_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            // Data arrives MSB-aligned after DBIT right shifts; realign to bit 0.
            if (rx_s) begin
              dout_d  = b_q >> (8 - DBIT);
              done_d  = 1'b1;
              state_d = RX_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = RX_WAIT_HI;
            end
          end else begin
            s_cnt_d = s_cnt_q + SCW'(1);
          end
        end
      end
      RX_WAIT_HI: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, random frames against
// a frame-level model, and hand sequences for glitch, break, reset and DBIT=7.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned BIT_CLK = 4 * OVERSAMPLE;

  logic       clk, reset, s_tick, rx8, rx7;
  logic [7:0] dout8, dout7;
  logic       done8, done7, ferr8, ferr7;

  uart_rx dut8 (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx8),
    .dout         (dout8),
    .rx_done_tick (done8),
    .frame_err    (ferr8)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx7),
    .dout         (dout7),
    .rx_done_tick (done7),
    .frame_err    (ferr7)
  );

  typedef struct {
    logic [7:0]  data;
    logic        stop_ok;
    int unsigned gap_bits;
    int unsigned exp_done;
    int unsigned exp_ferr;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t        vecs[8];
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned n_done8 = 0, n_ferr8 = 0, n_both8 = 0;
  int unsigned n_done7 = 0, n_ferr7 = 0, n_both7 = 0;
  int unsigned cyc = 0, done7_cyc = 0, tphase = 0;
  int unsigned d0, f0, start_cyc, gap;
  logic [7:0]  model_dout, rdata, exp7;
  logic        stop_ok;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      s_tick = (tphase == 3);
      tphase = (tphase + 1) % 4;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done8) n_done8++;
    if (ferr8) n_ferr8++;
    if (done8 && ferr8) n_both8++;
    if (done7) begin
      n_done7++;
      done7_cyc = cyc;
    end
    if (ferr7) n_ferr7++;
    if (done7 && ferr7) n_both7++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input int unsigned line, input logic lvl, input int unsigned nclk);
    if (line == 0) rx8 = lvl;
    else           rx7 = lvl;
    repeat (nclk) @(negedge clk);
    #1;
  endtask

  // Leaves the caller just after a negedge with the next s_tick 4 posedges out.
  task automatic align_tick();
    @(negedge clk); #1;
    while (!s_tick) begin
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
  endtask

  task automatic send_frame(input int unsigned line, input logic [7:0] data,
                            input int unsigned nbits, input logic stop_lvl,
                            input int unsigned stop_clk);
    drive(line, 1'b0, BIT_CLK);
    for (int unsigned i = 0; i < nbits; i++) drive(line, data[i], BIT_CLK);
    drive(line, stop_lvl, stop_clk);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 2, 1, 0, 8'h55};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 2, 1, 0, 8'hFF};
    vecs[3] = '{8'hA5, 1'b0, 2, 0, 1, 8'hFF};
    vecs[4] = '{8'h3C, 1'b1, 1, 1, 0, 8'h3C};
    vecs[5] = '{8'h01, 1'b1, 0, 1, 0, 8'h01};
    vecs[6] = '{8'h80, 1'b1, 1, 1, 0, 8'h80};
    vecs[7] = '{8'hC3, 1'b0, 1, 0, 1, 8'h80};

    reset = 1'b1; rx8 = 1'b1; rx7 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset dout8", 32'(dout8), 32'h0);
    check("reset done8", 32'(done8), 32'h0);
    check("reset ferr8", 32'(ferr8), 32'h0);
    check("reset dout7", 32'(dout7), 32'h0);
    reset = 1'b0;
    drive(0, 1'b1, 2 * BIT_CLK);
    model_dout = 8'h00;

    align_tick();
    for (int i = 0; i < 8; i++) begin
      d0 = n_done8; f0 = n_ferr8;
      send_frame(0, vecs[i].data, 8, vecs[i].stop_ok, BIT_CLK);
      check($sformatf("vec%0d done", i), n_done8 - d0, vecs[i].exp_done);
      check($sformatf("vec%0d ferr", i), n_ferr8 - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d dout", i), 32'(dout8), 32'(vecs[i].exp_dout));
      if (vecs[i].stop_ok) model_dout = vecs[i].data;
      if (vecs[i].gap_bits != 0) drive(0, 1'b1, vecs[i].gap_bits * BIT_CLK);
    end

    for (int i = 0; i < 20; i++) begin
      rdata   = 8'($urandom_range(255));
      stop_ok = ($urandom_range(3) != 0);
      gap     = stop_ok ? $urandom_range(2) : 1 + $urandom_range(1);
      d0 = n_done8; f0 = n_ferr8;
      send_frame(0, rdata, 8, stop_ok, BIT_CLK);
      if (stop_ok) model_dout = rdata;
      check($sformatf("rand%0d done", i), n_done8 - d0, stop_ok ? 32'd1 : 32'd0);
      check($sformatf("rand%0d ferr", i), n_ferr8 - f0, stop_ok ? 32'd0 : 32'd1);
      check($sformatf("rand%0d dout", i), 32'(dout8), 32'(model_dout));
      if (gap != 0) drive(0, 1'b1, gap * BIT_CLK);
    end

    // Start-bit glitch: 5 ticks low, then idle.
    align_tick();
    d0 = n_done8; f0 = n_ferr8;
    drive(0, 1'b0, 20);
    drive(0, 1'b1, 3 * BIT_CLK);
    check("glitch done", n_done8 - d0, 32'd0);
    check("glitch ferr", n_ferr8 - f0, 32'd0);
    check("glitch dout", 32'(dout8), 32'(model_dout));

    // Bad stop bit followed by a 10-bit break, then a clean frame.
    align_tick();
    d0 = n_done8; f0 = n_ferr8;
    send_frame(0, 8'hA5, 8, 1'b0, 11 * BIT_CLK);
    drive(0, 1'b1, 2 * BIT_CLK);
    check("break ferr", n_ferr8 - f0, 32'd1);
    check("break done", n_done8 - d0, 32'd0);
    check("break dout", 32'(dout8), 32'(model_dout));
    d0 = n_done8;
    send_frame(0, 8'h3C, 8, 1'b1, BIT_CLK);
    drive(0, 1'b1, BIT_CLK);
    model_dout = 8'h3C;
    check("after break done", n_done8 - d0, 32'd1);
    check("after break dout", 32'(dout8), 32'(model_dout));

    // Reset pulse in the middle of data bit 4 of 0x81.
    align_tick();
    d0 = n_done8; f0 = n_ferr8;
    rdata = 8'h81;
    drive(0, 1'b0, BIT_CLK);
    for (int unsigned i = 0; i < 4; i++) drive(0, rdata[i], BIT_CLK);
    drive(0, rdata[4], BIT_CLK / 2);
    reset = 1'b1; rx8 = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    model_dout = 8'h00;
    check("mid-reset dout", 32'(dout8), 32'(model_dout));
    check("mid-reset done", 32'(done8), 32'h0);
    check("mid-reset ferr", 32'(ferr8), 32'h0);
    drive(0, 1'b1, 3 * BIT_CLK);
    check("mid-reset no done", n_done8 - d0, 32'd0);
    check("mid-reset no ferr", n_ferr8 - f0, 32'd0);
    align_tick();
    d0 = n_done8;
    send_frame(0, 8'h7E, 8, 1'b1, BIT_CLK);
    drive(0, 1'b1, BIT_CLK);
    model_dout = 8'h7E;
    check("post-reset done", n_done8 - d0, 32'd1);
    check("post-reset dout", 32'(dout8), 32'(model_dout));

    // DBIT=7, two stop bits: done after 8 + 16*7 + 32 ticks of 4 clk.
    align_tick();
    start_cyc = cyc;
    d0 = n_done7; f0 = n_ferr7;
    send_frame(1, 8'h5A, 7, 1'b1, 2 * BIT_CLK);
    drive(1, 1'b1, BIT_CLK);
    exp7 = 8'h5A & 8'((1 << 7) - 1);
    check("dbit7 done", n_done7 - d0, 32'd1);
    check("dbit7 ferr", n_ferr7 - f0, 32'd0);
    check("dbit7 dout", 32'(dout7), 32'(exp7));
    check("dbit7 latency", done7_cyc - start_cyc, 4 * (OVERSAMPLE / 2 + OVERSAMPLE * 7 + 32));
    d0 = n_done7;
    send_frame(1, 8'hFF, 7, 1'b1, 2 * BIT_CLK);
    drive(1, 1'b1, BIT_CLK);
    exp7 = 8'hFF & 8'((1 << 7) - 1);
    check("dbit7 ones done", n_done7 - d0, 32'd1);
    check("dbit7 ones dout", 32'(dout7), 32'(exp7));

    check("done/ferr overlap 8", n_both8, 32'd0);
    check("done/ferr overlap 7", n_both7, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
